// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between two
// valid/ready requesters, with a hardware zero-fill sweep of the whole array.
module memory_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear_req,
   output logic                  clear_busy,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_data,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_data,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_input,
   output logic                  mem_write_enable,
   input  logic [DATA_WIDTH-1:0] mem_data_output
);

   // Handshake: a request transfers on a rising edge where reqN_valid and
   // reqN_ready are both high; the requester holds valid and payload until then.

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
   logic                  rsp0_valid_q, rsp0_valid_d;
   logic                  rsp1_valid_q, rsp1_valid_d;
   logic                  can_grant;
   logic                  grant0;
   logic                  grant1;

   // On a tie the requester that did not win last time is served.
   always_comb begin
      can_grant = (state_q == IDLE) && !reset && !clear_req;
      grant0    = can_grant && req0_valid && (!req1_valid || last_grant_q);
      grant1    = can_grant && req1_valid && (!req0_valid || !last_grant_q);
   end

   always_comb begin
      state_d      = state_q;
      sweep_d      = sweep_q;
      last_grant_d = last_grant_q;
      rsp0_valid_d = grant0 && !req0_we;
      rsp1_valid_d = grant1 && !req1_we;
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d = CLEAR;
               sweep_d = '0;
            end else if (grant0) begin
               last_grant_d = 1'b0;
            end else if (grant1) begin
               last_grant_d = 1'b1;
            end
         end
         CLEAR: begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == '1) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         sweep_q      <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         sweep_q      <= sweep_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
      end
   end

   // Sweep writes are suppressed during reset so an aborted sweep stops at once.
   always_comb begin
      mem_address      = '0;
      mem_data_input   = '0;
      mem_write_enable = 1'b0;
      if (state_q == CLEAR) begin
         mem_address      = sweep_q;
         mem_write_enable = !reset;
      end else if (grant0) begin
         mem_address      = req0_addr;
         mem_data_input   = req0_wdata;
         mem_write_enable = req0_we;
      end else if (grant1) begin
         mem_address      = req1_addr;
         mem_data_input   = req1_wdata;
         mem_write_enable = req1_we;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign clear_busy = (state_q == CLEAR);
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_data  = mem_data_output;
   assign rsp1_data  = mem_data_output;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a stand-in memory, a request-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_memory_arbiter;
   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          clear_req = 1'b0;
   logic          clear_busy;
   logic          req0_valid = 1'b0, req0_we = 1'b0;
   logic [AW-1:0] req0_addr = '0;
   logic [DW-1:0] req0_wdata = '0;
   logic          req1_valid = 1'b0, req1_we = 1'b0;
   logic [AW-1:0] req1_addr = '0;
   logic [DW-1:0] req1_wdata = '0;
   logic          req0_ready, req1_ready;
   logic          rsp0_valid, rsp1_valid;
   logic [DW-1:0] rsp0_data, rsp1_data;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data_input;
   logic          mem_write_enable;
   logic [DW-1:0] mem_data_output;

   always #5 clk = ~clk;

   memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
      .mem_address(mem_address), .mem_data_input(mem_data_input),
      .mem_write_enable(mem_write_enable), .mem_data_output(mem_data_output)
   );

   // Stand-in single-port synchronous memory.
   logic [DW-1:0] ram [DEPTH];
   logic [DW-1:0] ram_dout = '0;
   always @(posedge clk) begin
      if (mem_write_enable) ram[mem_address] <= mem_data_input;
      ram_dout <= ram[mem_address];
   end
   assign mem_data_output = ram_dout;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: clear cycles remaining, the last winner, pending responses.
   int            m_left = 0;
   int            m_sweep = 0;
   int            m_last = 1;
   bit            m_pend [2];
   logic [DW-1:0] m_pdata [2];
   logic [DW-1:0] m_mem [DEPTH];
   int            mg;
   int            cg;
   bit            cbusy;
   logic [AW-1:0] ea;
   logic [DW-1:0] ed;
   logic          ewe;

   function automatic int model_grant();
      if (reset || m_left > 0 || clear_req) return -1;
      if (req0_valid && req1_valid) return 1 - m_last;
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   always @(posedge clk) begin
      mg = model_grant();
      m_pend[0] = 1'b0;
      m_pend[1] = 1'b0;
      if (reset) begin
         m_left = 0;
         m_sweep = 0;
         m_last = 1;
      end else if (m_left > 0) begin
         m_mem[m_sweep] = '0;
         m_sweep++;
         m_left--;
      end else if (clear_req) begin
         m_left = DEPTH;
         m_sweep = 0;
      end else if (mg == 0) begin
         m_last = 0;
         if (req0_we) m_mem[req0_addr] = req0_wdata;
         else begin m_pend[0] = 1'b1; m_pdata[0] = m_mem[req0_addr]; end
      end else if (mg == 1) begin
         m_last = 1;
         if (req1_we) m_mem[req1_addr] = req1_wdata;
         else begin m_pend[1] = 1'b1; m_pdata[1] = m_mem[req1_addr]; end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         cg = model_grant();
         cbusy = (m_left > 0);
         ea = '0; ed = '0; ewe = 1'b0;
         if (cbusy) begin
            ea = AW'(m_sweep); ewe = !reset;
         end else if (cg == 0) begin
            ea = req0_addr; ed = req0_wdata; ewe = req0_we;
         end else if (cg == 1) begin
            ea = req1_addr; ed = req1_wdata; ewe = req1_we;
         end
         chk("ready0", req0_ready, cg == 0);
         chk("ready1", req1_ready, cg == 1);
         chk("clear_busy", clear_busy, cbusy);
         chk("mem_we", mem_write_enable, ewe);
         chk("mem_addr", mem_address, ea);
         chk("mem_din", mem_data_input, ed);
         chk("rsp0_valid", rsp0_valid, m_pend[0]);
         chk("rsp1_valid", rsp1_valid, m_pend[1]);
         if (m_pend[0]) chk("rsp0_data", rsp0_data, m_pdata[0]);
         if (m_pend[1]) chk("rsp1_data", rsp1_data, m_pdata[1]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int n, input logic v, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (n == 0) begin
         req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
      end
   endtask

   // Holds the request until accepted; returns just after the acceptance edge.
   task automatic do_req(input int n, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
      logic rdy;
      set_req(n, 1'b1, we, a, d);
      rdy = 1'b0;
      for (int k = 0; k < 50 && !rdy; k++) begin
         @(negedge clk);
         rdy = (n == 0) ? req0_ready : req1_ready;
         if (!rdy) step();
      end
      if (!rdy) chk("accept_timeout", rdy, 1);
      step();
      set_req(n, 1'b0, 1'b0, '0, '0);
   endtask

   // Returns at the first negedge with clear_busy low; cnt = busy cycles seen.
   task automatic wait_clear(output int cnt);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!clear_busy) break;
         cnt++;
         step();
      end
      if (clear_busy) chk("clear_timeout", clear_busy, 0);
   endtask

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] got;
   int            bc;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram[i] = '0;
         m_mem[i] = '0;
      end
      set_req(0, 1'b1, 1'b1, 4'h3, 8'h77);
      step();
      step();
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_we", mem_write_enable, 0);
      chk("rst_busy", clear_busy, 0);
      chk("rst_rsp0", rsp0_valid, 0);
      step();
      reset = 1'b0;
      set_req(0, 1'b0, 1'b0, '0, '0);
      step();

      // Write then read back through requester 0.
      do_req(0, 1'b1, 4'h3, 8'hA5);
      do_req(0, 1'b0, 4'h3, 8'h00);
      @(negedge clk);
      chk("rd_rsp0_valid", rsp0_valid, 1);
      chk("rd_rsp0_data", rsp0_data, 8'hA5);
      chk("rd_rsp1_valid", rsp1_valid, 0);
      step();

      // Tie-break alternation; preload via requester 1 so requester 0 wins first.
      do_req(1, 1'b1, 4'h1, 8'h11);
      do_req(1, 1'b1, 4'h2, 8'h22);
      exp_q = '{8'd0, 8'd1, 8'd0, 8'd1};
      set_req(0, 1'b1, 1'b0, 4'h1, 8'h00);
      set_req(1, 1'b1, 1'b0, 4'h2, 8'h00);
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin
            set_req(0, 1'b0, 1'b0, '0, '0);
            set_req(1, 1'b0, 1'b0, '0, '0);
         end
         @(negedge clk);
         if (k > 0) begin
            if (k % 2 == 1) chk("alt_rsp0_data", rsp0_valid ? rsp0_data : 8'hXX, 8'h11);
            else            chk("alt_rsp1_data", rsp1_valid ? rsp1_data : 8'hXX, 8'h22);
         end
         if (k < 4) begin
            got = req1_ready ? 8'd1 : (req0_ready ? 8'd0 : 8'd2);
            chk("alt_grant", got, exp_q.pop_front());
         end
         step();
      end

      // Requester 1 alone for three cycles, then a tie goes to requester 0.
      set_req(1, 1'b1, 1'b0, 4'h2, 8'h00);
      step(); step(); step();
      set_req(0, 1'b1, 1'b0, 4'h1, 8'h00);
      @(negedge clk);
      chk("tie_ready0", req0_ready, 1);
      chk("tie_ready1", req1_ready, 0);
      step();
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      step();

      // Full sweep with a request stalled across it.
      for (int i = 0; i < DEPTH; i++) do_req(0, 1'b1, AW'(i), 8'hFF);
      set_req(0, 1'b1, 1'b0, 4'h0, 8'h00);
      clear_req = 1'b1;
      @(negedge clk);
      chk("clr_refuse0", req0_ready, 0);
      step();
      clear_req = 1'b0;
      wait_clear(bc);
      chk("clr_cycles", bc, 16);
      chk("clr_after_ready0", req0_ready, 1);
      step();
      set_req(0, 1'b0, 1'b0, '0, '0);
      do_req(0, 1'b0, 4'h7, 8'h00);
      @(negedge clk);
      chk("clr_word7", rsp0_data, 8'h00);
      step();
      do_req(0, 1'b0, 4'hF, 8'h00);

      // Reset at sweep cycle 5 aborts the sweep.
      for (int i = 0; i < DEPTH; i++) do_req(0, 1'b1, AW'(i), 8'hFF);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      repeat (5) step();
      reset = 1'b1;
      @(negedge clk);
      chk("abort_we", mem_write_enable, 0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", clear_busy, 0);
      step();
      do_req(0, 1'b0, 4'h4, 8'h00);
      @(negedge clk);
      chk("abort_word4", rsp0_data, 8'h00);
      step();
      do_req(0, 1'b0, 4'h5, 8'h00);
      @(negedge clk);
      chk("abort_word5", rsp0_data, 8'hFF);
      step();
      do_req(0, 1'b0, 4'hF, 8'h00);
      @(negedge clk);
      chk("abort_word15", rsp0_data, 8'hFF);
      step();

      // Read in the same cycle as clear_req is refused and served after the sweep.
      do_req(0, 1'b1, 4'h9, 8'h5C);
      set_req(0, 1'b1, 1'b0, 4'h9, 8'h00);
      clear_req = 1'b1;
      @(negedge clk);
      chk("same_refuse0", req0_ready, 0);
      step();
      clear_req = 1'b0;
      wait_clear(bc);
      chk("same_ready0", req0_ready, 1);
      step();
      set_req(0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk("same_rsp0_data", rsp0_valid ? rsp0_data : 8'hXX, 8'h00);
      step();

      // Read accepted just before clear_req still gets its response.
      do_req(0, 1'b1, 4'h9, 8'h5C);
      do_req(0, 1'b0, 4'h9, 8'h00);
      clear_req = 1'b1;
      @(negedge clk);
      chk("pre_rsp0_valid", rsp0_valid, 1);
      chk("pre_rsp0_data", rsp0_data, 8'h5C);
      step();
      clear_req = 1'b0;
      @(negedge clk);
      chk("pre_busy", clear_busy, 1);
      chk("pre_rsp0_gone", rsp0_valid, 0);
      step();
      wait_clear(bc);
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
